regfile_mp: RTL

//  Parametrised multi-port register file: NUM_WR write ports, NUM_RD read ports, optional

---
 rtl/regfile_mp.sv | 109 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clearing sweep, optional zero register,
// optional write->read bypass and a per-register busy scoreboard for hazard detection.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wEnable_i,
    input  logic [NUM_WR*ADDR_W-1:0] wAddr_i,
    input  logic [NUM_WR*DATA_W-1:0] wData_i,
    input  logic [NUM_RD-1:0]        rEnable_i,
    input  logic [NUM_RD*ADDR_W-1:0] rAddr_i,
    output logic [NUM_RD*DATA_W-1:0] rData_o,
    output logic [NUM_RD-1:0]        rBusy_o,
    input  logic                     resv_i,
    input  logic [ADDR_W-1:0]        resvAddr_i,
    output logic                     ready_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                ready_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DEPTH-1:0]    busy_q;

    assign ready_o = ready_q;

    // Register contents are not reset directly; the INIT sweep clears them one per edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    regs_q[idx_q] <= '0;
                    idx_q         <= idx_q + 1'b1;
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Later ports overwrite earlier ones, so the highest index wins.
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wEnable_i[k]) begin
                            busy_q[wAddr_i[k*ADDR_W +: ADDR_W]] <= 1'b0;
                            if (!(ZERO_REG != 0 && wAddr_i[k*ADDR_W +: ADDR_W] == '0))
                                regs_q[wAddr_i[k*ADDR_W +: ADDR_W]] <= wData_i[k*DATA_W +: DATA_W];
                        end
                    end
                    // A new reservation outranks a clearing write from an older producer.
                    if (resv_i && !(ZERO_REG != 0 && resvAddr_i == '0))
                        busy_q[resvAddr_i] <= 1'b1;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [DATA_W-1:0] byp;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra = rAddr_i[g*ADDR_W +: ADDR_W];

        always_comb begin
            hit = 1'b0;
            byp = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (BYPASS != 0 && wEnable_i[k] && wAddr_i[k*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    byp = wData_i[k*DATA_W +: DATA_W];
                end
            end
        end

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (ready_q && rEnable_i[g]) begin
                if (ZERO_REG != 0 && ra == '0)
                    rd = '0;
                else if (hit)
                    rd = byp;
                else
                    rd = regs_q[ra];
                rb = busy_q[ra] & ~hit;
            end
        end

        assign rData_o[g*DATA_W +: DATA_W] = rd;
        assign rBusy_o[g]                  = rb;
    end

endmodule
